// File: rtl/scan_mux.sv
// Scanning channel multiplexer: round-robin or manual channel selection with
// per-channel masking, registered data/valid, wrap pulse and select error flag.
module scan_mux #(
    parameter int DATA_W = 1,
    parameter int N_CH   = 4,
    localparam int SEL_W = (N_CH > 2) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         man_sel,
    input  logic [N_CH-1:0]          ch_mask,
    input  logic [N_CH*DATA_W-1:0]   din,
    output logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        dout,
    output logic                     valid,
    output logic                     wrap,
    output logic                     err
);

    logic [DATA_W-1:0] cur_data;
    logic              cur_en;
    logic              found_hi;
    logic              found_any;
    logic [SEL_W-1:0]  hi_idx;
    logic [SEL_W-1:0]  lo_idx;
    logic [SEL_W-1:0]  auto_next;
    logic              man_ok;

    // Data and mask bit of the currently selected channel.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        cur_data = '0;
        cur_en   = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (int'(sel) == k) begin
                cur_data = din[k*DATA_W +: DATA_W];
                cur_en   = ch_mask[k];
            end
        end
    end

    // Descending search leaves the smallest matching index in each result.
    always_comb begin
        found_hi  = 1'b0;
        found_any = 1'b0;
        hi_idx    = sel;
        lo_idx    = sel;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (ch_mask[k]) begin
                found_any = 1'b1;
                lo_idx    = SEL_W'(k);
                if (k > int'(sel)) begin
                    found_hi = 1'b1;
                    hi_idx   = SEL_W'(k);
                end
            end
        end
    end

    assign auto_next = found_hi ? hi_idx : lo_idx;
    assign man_ok    = int'(man_sel) < N_CH;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel   <= '0;
            dout  <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
            err   <= 1'b0;
        end else if (en) begin
            // Masked channel: output zero rather than stale data.
            dout  <= cur_en ? cur_data : '0;
            valid <= cur_en;
            if (mode) begin
                wrap <= 1'b0;
                if (man_ok) begin
                    sel <= man_sel;
                    err <= 1'b0;
                end else begin
                    err <= 1'b1;
                end
            end else begin
                err <= 1'b0;
                if (found_any) begin
                    sel  <= auto_next;
                    wrap <= !found_hi;
                end else begin
                    wrap <= 1'b0;
                end
            end
        end else begin
            valid <= 1'b0;
        end
    end

endmodule
